accum_bank: RTL and testbench

Multi-channel accumulator bank: successor to the single-register accumulator, generalised to `CH` independent channels with a wider accumulator than the input. Each accepted sample is added into the channel selected on the input side. On request, a read-and-clear dump streams every channel out through a valid/ready port. The block sits between a sample source (event counters, ADC binning) and a bus-side reader.

---
 rtl/accum_bank.sv | 161 ++++++++++++++++
 tb/tb_accum_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/accum_bank.sv
// accum_bank: CH-channel accumulator bank with a read-and-clear dump over a valid/ready port.
// Build option: define ACCUM_BANK_SAT_EN to saturate on overflow instead of wrapping modulo 2^W.

module accum_bank_ch #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         add_en_i,
  input  logic [N-1:0] data_i,
  input  logic         clr_i,
  output logic [W-1:0] acc_o,
  output logic         ovf_o
);
  localparam int W1 = W + 1;

  logic [W-1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;
  logic [W:0]   sum;

  // one spare bit catches the carry out of the W-bit accumulator
  assign sum = {1'b0, acc_q} + W1'(data_i);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_en_i) begin
      acc_d = sum[W-1:0];
      if (sum[W]) begin
        ovf_d = 1'b1;
`ifdef ACCUM_BANK_SAT_EN
        acc_d = '1;
`else
        acc_d = sum[W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

module accum_bank #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CH = 4,
  parameter int CW = $clog2(CH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          In_Valid,
  output logic          In_Ready,
  input  logic [CW-1:0] In_Chan,
  input  logic [N-1:0]  Data,
  input  logic          Dump_Req,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic [CW-1:0] Out_Chan,
  output logic [W-1:0]  Q,
  output logic          Ovf,
  output logic          Out_Last
);
  typedef enum logic {ST_ACC, ST_DUMP} state_t;

  state_t               state_q;
  logic [CW-1:0]        ptr_q;
  logic                 in_ready_q, out_valid_q;
  logic [CH-1:0][W-1:0] acc;
  logic [CH-1:0]        ovf;
  logic                 in_fire, out_fire, ptr_last;
  logic [W-1:0]         q_sel;
  logic                 ovf_sel;

  assign in_fire  = In_Valid & in_ready_q;
  assign out_fire = out_valid_q & Out_Ready;
  assign ptr_last = (ptr_q == CW'(CH - 1));

  // channel indices >= CH match no lane, so such samples are swallowed
  for (genvar i = 0; i < CH; i++) begin : g_ch
    accum_bank_ch #(.N(N), .W(W)) u_ch (
      .Clk      (Clk),
      .Reset    (Reset),
      .add_en_i (in_fire && (In_Chan == CW'(i))),
      .data_i   (Data),
      .clr_i    (out_fire && (ptr_q == CW'(i))),
      .acc_o    (acc[i]),
      .ovf_o    (ovf[i])
    );
  end

  always_comb begin
    q_sel   = '0;
    ovf_sel = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (ptr_q == CW'(i)) begin
        q_sel   = acc[i];
        ovf_sel = ovf[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_ACC;
      ptr_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (Dump_Req) begin
            state_q     <= ST_DUMP;
            ptr_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (out_fire) begin
            if (ptr_last) begin
              state_q     <= ST_ACC;
              ptr_q       <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        default: begin
          state_q     <= ST_ACC;
          ptr_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Out_Chan  = out_valid_q ? ptr_q : '0;
  assign Q         = out_valid_q ? q_sel : '0;
  assign Ovf       = out_valid_q & ovf_sel;
  assign Out_Last  = out_valid_q & ptr_last;
endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: vector table, directed corner sequences, randomized run vs. reference model.
module tb_accum_bank;
  localparam int N = 4, W = 8, CH = 4, CW = 2;
  localparam int CH5 = 5, CW5 = 3;
`ifdef ACCUM_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset, In_Valid, In_Ready, Dump_Req, Out_Valid, Out_Ready, Ovf, Out_Last;
  logic [CW-1:0] In_Chan, Out_Chan;
  logic [N-1:0]  Data;
  logic [W-1:0]  Q;

  logic           r5, iv5, ir5, dr5, ov5, ordy5, ovf5, last5;
  logic [CW5-1:0] ich5, och5;
  logic [N-1:0]   d5;
  logic [W-1:0]   q5;

  accum_bank #(.N(N), .W(W), .CH(CH)) u_dut (
    .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Chan(In_Chan),
    .Data(Data), .Dump_Req(Dump_Req), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Chan(Out_Chan), .Q(Q), .Ovf(Ovf), .Out_Last(Out_Last));

  accum_bank #(.N(N), .W(W), .CH(CH5)) u_dut5 (
    .Clk(Clk), .Reset(r5), .In_Valid(iv5), .In_Ready(ir5), .In_Chan(ich5),
    .Data(d5), .Dump_Req(dr5), .Out_Valid(ov5), .Out_Ready(ordy5),
    .Out_Chan(och5), .Q(q5), .Ovf(ovf5), .Out_Last(last5));

  int nchk = 0, nerr = 0;

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference model: per-channel totals plus "dumping" flag and next channel to read
  int m_acc[CH];
  bit m_ovf[CH];
  bit m_dump;
  int m_idx;

  function automatic void m_step(bit rst, bit iv, int ich, int dat, bit dreq, bit ordy);
    int s;
    if (rst) begin
      foreach (m_acc[i]) begin m_acc[i] = 0; m_ovf[i] = 0; end
      m_dump = 0; m_idx = 0;
    end else if (!m_dump) begin
      if (iv && ich < CH) begin
        s = m_acc[ich] + dat;
        if (s >= 2**W) begin
          m_ovf[ich] = 1;
          s = SAT ? (2**W - 1) : (s % (2**W));
        end
        m_acc[ich] = s;
      end
      if (dreq) begin m_dump = 1; m_idx = 0; end
    end else if (ordy) begin
      m_acc[m_idx] = 0; m_ovf[m_idx] = 0;
      if (m_idx == CH - 1) m_dump = 0; else m_idx++;
    end
  endfunction

  task automatic drv(bit rst, bit iv, int ich, int dat, bit dreq, bit ordy);
    Reset = rst; In_Valid = iv; In_Chan = CW'(ich); Data = N'(dat);
    Dump_Req = dreq; Out_Ready = ordy;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic cyc(bit rst, bit iv, int ich, int dat, bit dreq, bit ordy);
    drv(rst, iv, ich, dat, dreq, ordy);
    tick();
    m_step(rst, iv, ich, dat, dreq, ordy);
    chk("model.ir",   In_Ready,  !m_dump);
    chk("model.ov",   Out_Valid, m_dump);
    chk("model.ch",   Out_Chan,  m_dump ? m_idx : 0);
    chk("model.q",    Q,         m_dump ? m_acc[m_idx] : 0);
    chk("model.ovf",  Ovf,       m_dump ? m_ovf[m_idx] : 0);
    chk("model.last", Out_Last,  m_dump && (m_idx == CH - 1));
  endtask

  task automatic t5(bit rst, bit iv, int ich, int dat, bit dreq, bit ordy);
    r5 = rst; iv5 = iv; ich5 = CW5'(ich); d5 = N'(dat); dr5 = dreq; ordy5 = ordy;
    tick();
  endtask

  typedef struct {
    bit rst, iv; int ich, dat; bit dreq, ordy;
    bit e_ir, e_ov; int e_ch, e_q; bit e_ovf, e_last;
  } vec_t;

  function automatic vec_t mk(bit rst, bit iv, int ich, int dat, bit dreq, bit ordy,
                              bit e_ir, bit e_ov, int e_ch, int e_q, bit e_ovf, bit e_last);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ich = ich; v.dat = dat; v.dreq = dreq; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_ch = e_ch; v.e_q = e_q; v.e_ovf = e_ovf; v.e_last = e_last;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    r5 = 0; iv5 = 0; ich5 = '0; d5 = '0; dr5 = 0; ordy5 = 0;

    // basic accumulate and dump, then an empty re-dump
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) tbl[i] = mk(0, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 6; i <= 7; i++) tbl[i] = mk(0, 1, 2, 7, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 15, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0,  0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 1, 2, 14, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 0, 1, 3, 0,  0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0,  0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0,  0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 1, 2, 0,  0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 0, 1, 3, 0,  0, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0);

    for (int i = 0; i < 18; i++) begin
      drv(tbl[i].rst, tbl[i].iv, tbl[i].ich, tbl[i].dat, tbl[i].dreq, tbl[i].ordy);
      tick();
      chk($sformatf("vec%0d.ir", i),   In_Ready,  tbl[i].e_ir);
      chk($sformatf("vec%0d.ov", i),   Out_Valid, tbl[i].e_ov);
      chk($sformatf("vec%0d.ch", i),   Out_Chan,  tbl[i].e_ch);
      chk($sformatf("vec%0d.q", i),    Q,         tbl[i].e_q);
      chk($sformatf("vec%0d.ovf", i),  Ovf,       tbl[i].e_ovf);
      chk($sformatf("vec%0d.last", i), Out_Last,  tbl[i].e_last);
    end

    cyc(1, 0, 0, 0, 0, 0);

    // overflow: 18 x 15 into ch1 = 270
    repeat (18) cyc(0, 1, 1, 15, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovf.q", Q, SAT ? 255 : 14);
    chk("ovf.flag", Ovf, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("redump.q", Q, 0);
    chk("redump.flag", Ovf, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);

    // backpressure on ch1
    cyc(0, 1, 1, 5, 0, 0);
    cyc(0, 1, 2, 6, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (3) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("bp.valid", Out_Valid, 1);
      chk("bp.chan", Out_Chan, 1);
      chk("bp.q", Q, 5);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk("bp.resume.chan", Out_Chan, 2);
    chk("bp.resume.q", Q, 6);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);

    // sample in the Dump_Req cycle lands; samples held during dump are refused
    cyc(0, 1, 3, 9, 1, 1);
    repeat (3) cyc(0, 1, 0, 1, 0, 1);
    chk("sim.q", Q, 9);
    chk("sim.ir", In_Ready, 0);
    cyc(0, 1, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("sim.refused.q", Q, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);

    // reset in the middle of a dump
    cyc(0, 1, 0, 4, 0, 0);
    cyc(0, 1, 1, 5, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst.pre.chan", Out_Chan, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst.ov", Out_Valid, 0);
    chk("rst.ir", In_Ready, 1);
    cyc(0, 0, 0, 0, 1, 1);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("rst.dump%0d.q", c), Q, 0);
      cyc(0, 0, 0, 0, 0, 1);
    end

    // out-of-range channel on the 5-channel instance
    t5(1, 0, 0, 0, 0, 0);
    t5(0, 1, 4, 3, 0, 0);
    t5(0, 1, 7, 9, 0, 0);
    chk("inv.ir", ir5, 1);
    t5(0, 1, 5, 2, 0, 0);
    t5(0, 0, 0, 0, 1, 1);
    for (int c = 0; c < CH5; c++) begin
      chk($sformatf("inv.ch%0d.chan", c), och5, c);
      chk($sformatf("inv.ch%0d.q", c), q5, (c == 4) ? 3 : 0);
      chk($sformatf("inv.ch%0d.last", c), last5, c == 4);
      t5(0, 0, 0, 0, 0, 1);
    end
    chk("inv.end.ov", ov5, 0);
    chk("inv.end.ir", ir5, 1);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, CH - 1),
          ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 15),
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
